// File: rtl/escalonador_zonas_rega_if.sv
// Zone scheduler bus: tank/zone requests in, valve/pump drive and status out.
// The tank side (master) drives requests; the scheduler (slave) drives actuators and status.
interface escalonador_zonas_rega_if #(
  parameter int N_ZONES = 4,
  parameter int DUR_W   = 8
);
  localparam int GW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  logic [N_ZONES-1:0] req;
  logic [DUR_W-1:0]   dur;
  logic               tank_ok;
  logic               tank_busy;
  logic               rain;
  logic [N_ZONES-1:0] valve;
  logic               pump;
  logic [GW-1:0]      grant;
  logic               busy;
  logic               done;
  logic               abrt;
  logic [1:0]         state_dbg;

  modport master (
    output req, dur, tank_ok, tank_busy, rain,
    input  valve, pump, grant, busy, done, abrt, state_dbg
  );

  modport slave (
    input  req, dur, tank_ok, tank_busy, rain,
    output valve, pump, grant, busy, done, abrt, state_dbg
  );
endinterface

// File: rtl/escalonador_zonas_rega.sv
// Round-robin irrigation scheduler sharing one tank/pump across N_ZONES zones.
// Optional macro RAIN_INHIBIT_EN: rain blocks new grants and aborts watering.
module escalonador_zonas_rega #(
  parameter int N_ZONES   = 4,
  parameter int DUR_W     = 8,
  parameter int OPEN_CYC  = 4,
  parameter int CLOSE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  escalonador_zonas_rega_if.slave zr
);
  // Handshake: req is a level held by a zone while it wants water; a grant is
  // accepted in IDLE only when the tank is ready, and the grant ends with exactly
  // one done (normal) or abrt (tank dry) pulse in the first IDLE cycle.

  localparam int GW    = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int CW_O  = $clog2(OPEN_CYC + 1);
  localparam int CW_C  = $clog2(CLOSE_CYC + 1);
  localparam int CW_T  = (CW_O > CW_C) ? CW_O : CW_C;
  localparam int CNT_W = (DUR_W > CW_T) ? DUR_W : CW_T;
  localparam logic [N_ZONES-1:0] ONE_HOT0 = N_ZONES'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    WATER = 2'd2,
    CLOSE = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [GW-1:0]      ptr, ptr_n;
  logic [GW-1:0]      grant_q, grant_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DUR_W-1:0]   dur_q, dur_n;
  logic               abort_q, abort_n;
  logic               done_n, abrt_n;
  logic [N_ZONES-1:0] valve_q;
  logic               pump_q, busy_q, done_q, abrt_q;
  logic               pick_found;
  logic [GW-1:0]      pick_idx;
  logic               grant_block, water_abort;

`ifdef RAIN_INHIBIT_EN
  assign grant_block = zr.rain;
  assign water_abort = !zr.tank_ok || zr.rain;
`else
  logic unused_rain;
  assign unused_rain = zr.rain;
  assign grant_block = 1'b0;
  assign water_abort = !zr.tank_ok;
`endif

  // Scan from the highest offset down so the zone closest to ptr wins last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= N_ZONES) idx = idx - N_ZONES;
      if (zr.req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    grant_n = grant_q;
    cnt_n   = cnt;
    dur_n   = dur_q;
    abort_n = abort_q;
    done_n  = 1'b0;
    abrt_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (zr.tank_ok && !zr.tank_busy && !grant_block && pick_found) begin
          state_n = OPEN;
          grant_n = pick_idx;
          dur_n   = (zr.dur == '0) ? DUR_W'(1) : zr.dur;
          cnt_n   = CNT_W'(OPEN_CYC - 1);
          abort_n = 1'b0;
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_n = WATER;
          cnt_n   = CNT_W'(dur_q) - CNT_W'(1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WATER: begin
        if (water_abort) begin
          state_n = CLOSE;
          abort_n = 1'b1;
          cnt_n   = CNT_W'(CLOSE_CYC - 1);
        end else if (!zr.req[grant_q] || cnt == '0) begin
          state_n = CLOSE;
          abort_n = 1'b0;
          cnt_n   = CNT_W'(CLOSE_CYC - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      CLOSE: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (abort_q) begin
            abrt_n = 1'b1;
          end else begin
            done_n = 1'b1;
            ptr_n  = (int'(grant_q) == N_ZONES - 1) ? '0 : grant_q + GW'(1);
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      cnt     <= '0;
      dur_q   <= '0;
      abort_q <= 1'b0;
      valve_q <= '0;
      pump_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      grant_q <= grant_n;
      cnt     <= cnt_n;
      dur_q   <= dur_n;
      abort_q <= abort_n;
      valve_q <= (state_n != IDLE) ? (ONE_HOT0 << grant_n) : '0;
      pump_q  <= (state_n == WATER);
      busy_q  <= (state_n != IDLE);
      done_q  <= done_n;
      abrt_q  <= abrt_n;
    end
  end

  assign zr.valve     = valve_q;
  assign zr.pump      = pump_q;
  assign zr.grant     = grant_q;
  assign zr.busy      = busy_q;
  assign zr.done      = done_q;
  assign zr.abrt      = abrt_q;
  assign zr.state_dbg = state;
endmodule

// File: tb/tb_escalonador_zonas_rega.sv
// Directed bench for escalonador_zonas_rega with N_ZONES=4, OPEN_CYC=2, CLOSE_CYC=2.
module tb_escalonador_zonas_rega;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [1:0] exp_q[$];

  escalonador_zonas_rega_if #(.N_ZONES(4), .DUR_W(8)) zr ();

  escalonador_zonas_rega #(
    .N_ZONES(4), .DUR_W(8), .OPEN_CYC(2), .CLOSE_CYC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .zr(zr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver / monitor tasks
  task automatic observe(input int n, output int vc, output int pc, output int dc, output int ac);
    vc = 0; pc = 0; dc = 0; ac = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (zr.valve != 4'b0000) vc++;
      if (zr.pump) pc++;
      if (zr.done) dc++;
      if (zr.abrt) ac++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (zr.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++; if (zr.busy !== 1'b0) begin errors++; $error("FAIL idle_timeout observed=%0d expected=0", zr.busy); end
  endtask

  initial begin
    int vc, pc, dc, ac;
    int gap;
    bit first;
    logic prev_busy;
    logic [1:0] e;
    checks = 0; errors = 0;
    reset = 1'b1;
    zr.req = 4'b0000; zr.dur = 8'd0; zr.tank_ok = 1'b1; zr.tank_busy = 1'b0; zr.rain = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (zr.valve !== 4'b0000) begin errors++; $error("FAIL rst_valve observed=%0d expected=0", zr.valve); end
    checks++; if (zr.pump !== 1'b0) begin errors++; $error("FAIL rst_pump observed=%0d expected=0", zr.pump); end
    checks++; if (zr.grant !== 2'd0) begin errors++; $error("FAIL rst_grant observed=%0d expected=0", zr.grant); end
    checks++; if (zr.busy !== 1'b0) begin errors++; $error("FAIL rst_busy observed=%0d expected=0", zr.busy); end
    checks++; if (zr.done !== 1'b0) begin errors++; $error("FAIL rst_done observed=%0d expected=0", zr.done); end
    checks++; if (zr.abrt !== 1'b0) begin errors++; $error("FAIL rst_abrt observed=%0d expected=0", zr.abrt); end
    checks++; if (zr.state_dbg !== 2'd0) begin errors++; $error("FAIL rst_state observed=%0d expected=0", zr.state_dbg); end
    reset = 1'b0;

    // 1: single zone, dur=5 -> 9 valve cycles, 5 pump cycles, done
    zr.req = 4'b0010; zr.dur = 8'd5;
    @(negedge clk);
    checks++; if (zr.grant !== 2'd1) begin errors++; $error("FAIL t1_grant observed=%0d expected=1", zr.grant); end
    checks++; if (zr.valve !== 4'b0010) begin errors++; $error("FAIL t1_valve observed=%0d expected=2", zr.valve); end
    checks++; if (zr.pump !== 1'b0) begin errors++; $error("FAIL t1_pump_first observed=%0d expected=0", zr.pump); end
    checks++; if (zr.state_dbg !== 2'd1) begin errors++; $error("FAIL t1_state_open observed=%0d expected=1", zr.state_dbg); end
    observe(7, vc, pc, dc, ac);
    checks++; if (vc !== 7) begin errors++; $error("FAIL t1_valve_mid observed=%0d expected=7", vc); end
    checks++; if (pc !== 5) begin errors++; $error("FAIL t1_pump_cnt observed=%0d expected=5", pc); end
    zr.req = 4'b0000;
    observe(3, vc, pc, dc, ac);
    checks++; if (vc !== 1) begin errors++; $error("FAIL t1_valve_tail observed=%0d expected=1", vc); end
    checks++; if (pc !== 0) begin errors++; $error("FAIL t1_pump_tail observed=%0d expected=0", pc); end
    checks++; if (dc !== 1) begin errors++; $error("FAIL t1_done observed=%0d expected=1", dc); end

    // 2: all requesting; ptr=2 after zone 1, so order 2,3,0,1,2 with 1 idle cycle gaps
    zr.req = 4'b1111; zr.dur = 8'd1;
    exp_q.push_back(2'd2); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    first = 1'b1; gap = 0; prev_busy = 1'b0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (zr.busy && !prev_busy) begin
        e = exp_q.pop_front();
        checks++; if (zr.grant !== e) begin errors++; $error("FAIL t2_grant_order observed=%0d expected=%0d", zr.grant, e); end
        if (!first) begin
          checks++; if (gap !== 1) begin errors++; $error("FAIL t2_idle_gap observed=%0d expected=1", gap); end
        end
        first = 1'b0;
        gap = 0;
      end else if (!zr.busy) begin
        gap++;
      end
      prev_busy = zr.busy;
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $error("FAIL t2_all_grants observed=%0d expected=0", exp_q.size()); end
    zr.req = 4'b0000;
    wait_idle();

    // 3: zone 3 aborted by tank dry on 3rd WATER cycle, then re-granted before zone 0
    zr.req = 4'b1001; zr.dur = 8'd10;
    @(negedge clk);
    checks++; if (zr.grant !== 2'd3) begin errors++; $error("FAIL t3_grant observed=%0d expected=3", zr.grant); end
    repeat (2) @(negedge clk);
    checks++; if (zr.pump !== 1'b1) begin errors++; $error("FAIL t3_pump_w1 observed=%0d expected=1", zr.pump); end
    repeat (2) @(negedge clk);
    checks++; if (zr.pump !== 1'b1) begin errors++; $error("FAIL t3_pump_w3 observed=%0d expected=1", zr.pump); end
    zr.tank_ok = 1'b0;
    @(negedge clk);
    checks++; if (zr.pump !== 1'b0) begin errors++; $error("FAIL t3_pump_off observed=%0d expected=0", zr.pump); end
    checks++; if (zr.valve !== 4'b1000) begin errors++; $error("FAIL t3_valve_close observed=%0d expected=8", zr.valve); end
    checks++; if (zr.state_dbg !== 2'd3) begin errors++; $error("FAIL t3_state_close observed=%0d expected=3", zr.state_dbg); end
    zr.tank_ok = 1'b1;
    @(negedge clk);
    checks++; if (zr.valve !== 4'b1000) begin errors++; $error("FAIL t3_valve_close2 observed=%0d expected=8", zr.valve); end
    @(negedge clk);
    checks++; if (zr.abrt !== 1'b1) begin errors++; $error("FAIL t3_abrt observed=%0d expected=1", zr.abrt); end
    checks++; if (zr.done !== 1'b0) begin errors++; $error("FAIL t3_no_done observed=%0d expected=0", zr.done); end
    checks++; if (zr.valve !== 4'b0000) begin errors++; $error("FAIL t3_valve_off observed=%0d expected=0", zr.valve); end
    @(negedge clk);
    checks++; if (zr.grant !== 2'd3) begin errors++; $error("FAIL t3_regrant observed=%0d expected=3", zr.grant); end
    checks++; if (zr.busy !== 1'b1) begin errors++; $error("FAIL t3_regrant_busy observed=%0d expected=1", zr.busy); end
    zr.req = 4'b0000;
    wait_idle();

    // 4 + 5a: tank_busy holds IDLE; on release, dur=0 waters for one cycle
    zr.tank_busy = 1'b1; zr.req = 4'b0001; zr.dur = 8'd0;
    repeat (3) @(negedge clk);
    checks++; if (zr.busy !== 1'b0) begin errors++; $error("FAIL t4_busy_low observed=%0d expected=0", zr.busy); end
    checks++; if (zr.state_dbg !== 2'd0) begin errors++; $error("FAIL t4_state_idle observed=%0d expected=0", zr.state_dbg); end
    zr.tank_busy = 1'b0;
    @(negedge clk);
    checks++; if (zr.state_dbg !== 2'd1) begin errors++; $error("FAIL t4_open observed=%0d expected=1", zr.state_dbg); end
    checks++; if (zr.grant !== 2'd0) begin errors++; $error("FAIL t4_grant observed=%0d expected=0", zr.grant); end
    observe(4, vc, pc, dc, ac);
    checks++; if (pc !== 1) begin errors++; $error("FAIL t5_dur0_pump observed=%0d expected=1", pc); end
    checks++; if (vc !== 4) begin errors++; $error("FAIL t5_dur0_valve observed=%0d expected=4", vc); end
    zr.req = 4'b0000;
    @(negedge clk);
    checks++; if (zr.done !== 1'b1) begin errors++; $error("FAIL t5_dur0_done observed=%0d expected=1", zr.done); end
    checks++; if (zr.busy !== 1'b0) begin errors++; $error("FAIL t5_dur0_idle observed=%0d expected=0", zr.busy); end

    // 5b: soil wet early -> normal completion after 2 WATER cycles
    zr.req = 4'b0010; zr.dur = 8'd20;
    repeat (4) @(negedge clk);
    checks++; if (zr.grant !== 2'd1) begin errors++; $error("FAIL t5_grant observed=%0d expected=1", zr.grant); end
    checks++; if (zr.pump !== 1'b1) begin errors++; $error("FAIL t5_pump observed=%0d expected=1", zr.pump); end
    zr.req = 4'b0000;
    observe(3, vc, pc, dc, ac);
    checks++; if (vc !== 2) begin errors++; $error("FAIL t5_early_valve observed=%0d expected=2", vc); end
    checks++; if (pc !== 0) begin errors++; $error("FAIL t5_early_pump observed=%0d expected=0", pc); end
    checks++; if (dc !== 1) begin errors++; $error("FAIL t5_early_done observed=%0d expected=1", dc); end
    checks++; if (ac !== 0) begin errors++; $error("FAIL t5_early_abrt observed=%0d expected=0", ac); end

    // 6: async reset mid-WATER drops actuators before any clock edge, ptr back to 0
    zr.req = 4'b0100; zr.dur = 8'd20;
    repeat (3) @(negedge clk);
    checks++; if (zr.state_dbg !== 2'd2) begin errors++; $error("FAIL t6_state_water observed=%0d expected=2", zr.state_dbg); end
    checks++; if (zr.pump !== 1'b1) begin errors++; $error("FAIL t6_pump_on observed=%0d expected=1", zr.pump); end
    #2 reset = 1'b1;
    #1;
    checks++; if (zr.valve !== 4'b0000) begin errors++; $error("FAIL t6_valve_async observed=%0d expected=0", zr.valve); end
    checks++; if (zr.pump !== 1'b0) begin errors++; $error("FAIL t6_pump_async observed=%0d expected=0", zr.pump); end
    checks++; if (zr.busy !== 1'b0) begin errors++; $error("FAIL t6_busy_async observed=%0d expected=0", zr.busy); end
    zr.req = 4'b0110;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (zr.done !== 1'b0) begin errors++; $error("FAIL t6_no_done observed=%0d expected=0", zr.done); end
    checks++; if (zr.abrt !== 1'b0) begin errors++; $error("FAIL t6_no_abrt observed=%0d expected=0", zr.abrt); end
    @(negedge clk);
    checks++; if (zr.grant !== 2'd1) begin errors++; $error("FAIL t6_ptr_reset observed=%0d expected=1", zr.grant); end
    zr.req = 4'b0000;
    wait_idle();

`ifdef RAIN_INHIBIT_EN
    zr.rain = 1'b1; zr.req = 4'b0001; zr.dur = 8'd20;
    repeat (3) @(negedge clk);
    checks++; if (zr.busy !== 1'b0) begin errors++; $error("FAIL rain_blocks observed=%0d expected=0", zr.busy); end
    zr.rain = 1'b0;
    @(negedge clk);
    checks++; if (zr.busy !== 1'b1) begin errors++; $error("FAIL rain_release observed=%0d expected=1", zr.busy); end
    repeat (2) @(negedge clk);
    checks++; if (zr.pump !== 1'b1) begin errors++; $error("FAIL rain_pump_on observed=%0d expected=1", zr.pump); end
    zr.rain = 1'b1;
    observe(3, vc, pc, dc, ac);
    checks++; if (ac !== 1) begin errors++; $error("FAIL rain_abrt observed=%0d expected=1", ac); end
    checks++; if (dc !== 0) begin errors++; $error("FAIL rain_no_done observed=%0d expected=0", dc); end
    checks++; if (pc !== 0) begin errors++; $error("FAIL rain_pump_off observed=%0d expected=0", pc); end
    zr.rain = 1'b0; zr.req = 4'b0000;
    wait_idle();
`else
    zr.rain = 1'b1; zr.req = 4'b0001; zr.dur = 8'd1;
    @(negedge clk);
    checks++; if (zr.busy !== 1'b1) begin errors++; $error("FAIL rain_ignored observed=%0d expected=1", zr.busy); end
    zr.rain = 1'b0; zr.req = 4'b0000;
    wait_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
